// File: rtl/delay_mem_arbiter_if.sv
// Bus bundle between the delay-line buffer controllers, the shared sample memory and the
// round-robin arbiter that owns the memory port.
interface delay_mem_arbiter_if #(
    parameter int unsigned NReq      = 4,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrWidth = 12
);
    localparam int unsigned IdWidth = $clog2(NReq);

    logic                      enable;
    logic [NReq-1:0]           req_write;
    logic [NReq-1:0]           req_read;
    logic [NReq*AddrWidth-1:0] req_write_addr;
    logic [NReq*DataWidth-1:0] req_write_data;
    logic [NReq*AddrWidth-1:0] req_read_addr;
    logic [NReq-1:0]           write_ack;
    logic [NReq-1:0]           read_valid;
    logic [DataWidth-1:0]      read_data;
    logic                      mem_write_enable;
    logic [AddrWidth-1:0]      mem_write_addr;
    logic [DataWidth-1:0]      mem_write_data;
    logic                      mem_read_enable;
    logic [AddrWidth-1:0]      mem_read_addr;
    logic [DataWidth-1:0]      mem_read_data;
    logic                      busy;
    logic [IdWidth-1:0]        grant_id;

    modport master (
        input  enable, req_write, req_read, req_write_addr, req_write_data, req_read_addr,
               mem_read_data,
        output write_ack, read_valid, read_data, mem_write_enable, mem_write_addr,
               mem_write_data, mem_read_enable, mem_read_addr, busy, grant_id
    );

    modport slave (
        output enable, req_write, req_read, req_write_addr, req_write_data, req_read_addr,
               mem_read_data,
        input  write_ack, read_valid, read_data, mem_write_enable, mem_write_addr,
               mem_write_data, mem_read_enable, mem_read_addr, busy, grant_id
    );
endinterface

// File: rtl/delay_mem_arbiter.sv
// Round-robin arbiter giving each delay buffer controller an atomic write-then-read tenure
// on the shared sample memory (1-cycle synchronous read).
module delay_mem_arbiter #(
    parameter int unsigned NReq      = 4,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrWidth = 12
) (
    input logic                 clk_i,
    input logic                 reset_i,
    delay_mem_arbiter_if.master bus
);
    localparam int unsigned IdWidth = $clog2(NReq);

    typedef enum logic [2:0] {
        StIdle, StWrite, StReadIssue, StReadWait, StReadCap, StRelease
    } state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   rr_q, rr_d, grant_q, grant_d, gnt;
    logic                 we_q, we_d, re_q, re_d, busy_q, busy_d, any_cand;
    logic [AddrWidth-1:0] wa_q, wa_d, ra_q, ra_d;
    logic [DataWidth-1:0] wd_q, wd_d, rd_q, rd_d;
    logic [NReq-1:0]      ack_q, ack_d, val_q, val_d, cand;

    logic [AddrWidth-1:0] wr_addr [NReq];
    logic [AddrWidth-1:0] rd_addr [NReq];
    logic [DataWidth-1:0] wr_data [NReq];

    for (genvar i = 0; i < NReq; i++) begin : g_unpack
        assign wr_addr[i] = bus.req_write_addr[i*AddrWidth +: AddrWidth];
        assign rd_addr[i] = bus.req_read_addr[i*AddrWidth +: AddrWidth];
        assign wr_data[i] = bus.req_write_data[i*DataWidth +: DataWidth];
    end

    // Walk offsets from far to near so the requester closest to rr_q wins.
    always_comb begin : p_grant
        logic [IdWidth:0]   sum;
        logic [IdWidth-1:0] idx;
        cand     = bus.req_write | bus.req_read;
        any_cand = |cand;
        gnt      = '0;
        sum      = '0;
        idx      = '0;
        for (int k = NReq - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + (IdWidth + 1)'(k);
            if (sum >= (IdWidth + 1)'(NReq)) sum = sum - (IdWidth + 1)'(NReq);
            idx = IdWidth'(sum);
            if (cand[idx]) gnt = idx;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else if (bus.enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_cand) state_d = bus.req_write[gnt] ? StWrite : StReadWait;
            end
            StWrite:     state_d = bus.req_read[grant_q] ? StReadIssue : StRelease;
            StReadIssue: state_d = StReadWait;
            StReadWait:  state_d = StReadCap;
            StReadCap:   state_d = StRelease;
            StRelease:   state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        rr_d    = rr_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        ra_d    = ra_q;
        rd_d    = rd_q;
        ack_d   = '0;
        val_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (any_cand) begin
                    grant_d = gnt;
                    if (bus.req_write[gnt]) begin
                        wa_d = wr_addr[gnt];
                        wd_d = wr_data[gnt];
                        we_d = 1'b1;
                    end else begin
                        ra_d = rd_addr[gnt];
                        re_d = 1'b1;
                    end
                end
            end
            StWrite:     ack_d[grant_q] = 1'b1;
            StReadIssue: begin
                ra_d = rd_addr[grant_q];
                re_d = 1'b1;
            end
            StReadCap: begin
                rd_d           = bus.mem_read_data;
                val_d[grant_q] = 1'b1;
            end
            StRelease:   rr_d = (grant_q == IdWidth'(NReq - 1)) ? '0 : grant_q + 1'b1;
            default:     ;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q    <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            ra_q    <= '0;
            rd_q    <= '0;
            ack_q   <= '0;
            val_q   <= '0;
        end else if (bus.enable) begin
            rr_q    <= rr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            ra_q    <= ra_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            val_q   <= val_d;
        end
    end

    // A stalled cycle holds every register; strobes and pulses are masked so they fire once.
    assign bus.write_ack        = ack_q & {NReq{bus.enable}};
    assign bus.read_valid       = val_q & {NReq{bus.enable}};
    assign bus.mem_write_enable = we_q & bus.enable;
    assign bus.mem_read_enable  = re_q & bus.enable;
    assign bus.mem_write_addr   = wa_q;
    assign bus.mem_write_data   = wd_q;
    assign bus.mem_read_addr    = ra_q;
    assign bus.read_data        = rd_q;
    assign bus.busy             = busy_q;
    assign bus.grant_id         = grant_q;
endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Bench for delay_mem_arbiter: tenure-level reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_delay_mem_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delay_mem_arbiter_if #(.NReq(N), .DataWidth(DW), .AddrWidth(AW)) bus ();

    delay_mem_arbiter #(.NReq(N), .DataWidth(DW), .AddrWidth(AW)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    logic          en;
    logic [N-1:0]  req_w, req_r;
    logic [N*AW-1:0] wa_f, ra_f;
    logic [N*DW-1:0] wd_f;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] mrd_q;

    assign bus.enable         = en;
    assign bus.req_write      = req_w;
    assign bus.req_read       = req_r;
    assign bus.req_write_addr = wa_f;
    assign bus.req_write_data = wd_f;
    assign bus.req_read_addr  = ra_f;
    assign bus.mem_read_data  = mrd_q;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.mem_write_enable) mem[bus.mem_write_addr] <= bus.mem_write_data;
        if (bus.mem_read_enable) mrd_q <= mem[bus.mem_read_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] wa_of(int i); return wa_f[i*AW +: AW]; endfunction
    function automatic logic [AW-1:0] ra_of(int i); return ra_f[i*AW +: AW]; endfunction
    function automatic logic [DW-1:0] wd_of(int i); return wd_f[i*DW +: DW]; endfunction

    function automatic int pick(int rr, logic [N-1:0] c);
        for (int k = 0; k < N; k++) if (c[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // Tenure lengths in enabled cycles, counted from the granting IDLE cycle.
    function automatic int tlen(logic hw, logic hr);
        return hw ? (hr ? 6 : 3) : 4;
    endfunction

    // Reference model: position k within the current tenure advances on each enabled edge.
    logic [DW-1:0] ref_mem [4096];
    logic          m_busy, m_hasw, m_hasr;
    int            m_k, m_g, m_rr, g_now;
    logic [AW-1:0] m_wa, m_ra;
    logic [DW-1:0] m_wd, m_rd;

    always_comb g_now = pick(m_rr, req_w | req_r);

    always @(posedge clk or posedge rst) begin
        if (pl_en && !rst) ref_mem[pl_addr] <= pl_data;
        if (rst) begin
            m_busy <= 1'b0; m_hasw <= 1'b0; m_hasr <= 1'b0;
            m_k <= 0; m_g <= 0; m_rr <= 0;
            m_wa <= '0; m_ra <= '0; m_wd <= '0; m_rd <= '0;
        end else if (en) begin
            if (!m_busy) begin
                if (g_now >= 0) begin
                    m_busy <= 1'b1;
                    m_k    <= 1;
                    m_g    <= g_now;
                    m_hasw <= req_w[g_now];
                    m_hasr <= req_r[g_now];
                    if (req_w[g_now]) begin
                        m_wa <= wa_of(g_now);
                        m_wd <= wd_of(g_now);
                    end else begin
                        m_ra <= ra_of(g_now);
                    end
                end
            end else begin
                if (m_hasw && m_k == 1) begin
                    ref_mem[m_wa] <= m_wd;
                    m_hasr        <= req_r[m_g];
                end
                if (m_hasw && m_hasr && m_k == 2) m_ra <= ra_of(m_g);
                if (m_hasr && m_k == (m_hasw ? 4 : 2)) m_rd <= ref_mem[m_ra];
                if (m_k + 1 == tlen(m_hasw, m_hasr)) begin
                    m_busy <= 1'b0;
                    m_k    <= 0;
                    m_rr   <= (m_g + 1) % N;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    function automatic logic [N-1:0] oh(int g);
        logic [N-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic e_we();
        return en && m_busy && m_hasw && m_k == 1;
    endfunction
    function automatic logic e_re();
        return en && m_busy && (m_hasw ? (m_hasr && m_k == 3) : (m_k == 1));
    endfunction
    function automatic logic [N-1:0] e_ack();
        return (en && m_busy && m_hasw && m_k == 2) ? oh(m_g) : '0;
    endfunction
    function automatic logic [N-1:0] e_val();
        return (en && m_busy && m_hasr && m_k == (m_hasw ? 5 : 3)) ? oh(m_g) : '0;
    endfunction

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("busy", bus.busy, m_busy);
            chk("grant_id", bus.grant_id, m_g);
            chk("write_ack", bus.write_ack, e_ack());
            chk("read_valid", bus.read_valid, e_val());
            chk("mem_we", bus.mem_write_enable, e_we());
            chk("mem_re", bus.mem_read_enable, e_re());
            chk("read_data", bus.read_data, m_rd);
            chk("mem_wa", bus.mem_write_addr, m_wa);
            chk("mem_wd", bus.mem_write_data, m_wd);
            chk("mem_ra", bus.mem_read_addr, m_ra);
        end
    end

    logic [N-1:0] seen_ack, seen_val;

    // Advance n cycles, acting as the requesters: drop levels when acked/valid.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            seen_ack = bus.write_ack;
            seen_val = bus.read_valid;
            req_w    = req_w & ~seen_ack;
            req_r    = req_r & ~seen_val;
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic r, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        wa_f[i*AW +: AW] = wa;
        wd_f[i*DW +: DW] = wd;
        ra_f[i*AW +: AW] = ra;
        req_w[i] = w;
        req_r[i] = r;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step(1);
        pl_en = 1'b0;
    endtask

    function automatic int oh2i(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    int ord[$];
    int ocyc[$];
    int nval;
    logic saw_we;

    initial begin
        rst = 1'b1; en = 1'b1; chk_on = 1'b0;
        req_w = '0; req_r = '0; wa_f = '0; wd_f = '0; ra_f = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        seen_ack = '0; seen_val = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_rdata", bus.read_data, 16'h0);
        chk("rst_we", bus.mem_write_enable, 1'b0);
        chk("rst_ack", bus.write_ack, 4'h0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Round-robin: all four write-only, requester 0 re-requests after its first ack.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(12'h100 + i), DW'(16'hA000 + i), '0);
        ord.delete(); ocyc.delete();
        for (int c = 1; c <= 16; c++) begin
            step(1);
            if (|seen_ack) begin
                ord.push_back(oh2i(seen_ack));
                ocyc.push_back(c);
            end
            if (c == 2) req_w[0] = 1'b1;
            if (c % 3 == 1 && c <= 13) chk("rr_gid", bus.grant_id, (c / 3) % N);
        end
        chk("rr_count", ord.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ord.size()) begin
                chk("rr_order", ord[i], i % N);
                chk("rr_cycle", ocyc[i], 2 + 3 * i);
            end
        end

        // Write+read by requester 1 to the same address.
        set_req(1, 1'b1, 1'b1, 12'h010, 16'h1234, 12'h010);
        for (int c = 1; c <= 7; c++) begin
            step(1);
            if (c == 1) begin
                chk("wr_we", bus.mem_write_enable, 1'b1);
                chk("wr_addr", bus.mem_write_addr, 12'h010);
                chk("wr_data", bus.mem_write_data, 16'h1234);
            end
            if (c == 2) chk("wr_ack", seen_ack, 4'b0010);
            if (c == 3) chk("wr_noack", seen_ack, 4'b0000);
            if (c == 5) begin
                chk("wr_valid", seen_val, 4'b0010);
                chk("wr_rdata", bus.read_data, 16'h1234);
            end
            if (c == 6) chk("wr_busy_low", bus.busy, 1'b0);
        end

        // Read-only by requester 2.
        preload(12'h020, 16'hBEEF);
        preload(12'h030, 16'h0AAA);
        set_req(2, 1'b0, 1'b1, '0, '0, 12'h020);
        saw_we = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step(1);
            saw_we = saw_we | bus.mem_write_enable;
            if (c == 1) chk("ro_re_on", bus.mem_read_enable, 1'b1);
            if (c == 2) chk("ro_re_off", bus.mem_read_enable, 1'b0);
            if (c == 3) begin
                chk("ro_valid", seen_val, 4'b0100);
                chk("ro_rdata", bus.read_data, 16'hBEEF);
            end
        end
        chk("ro_nowrite", saw_we, 1'b0);

        // Enable stall of four edges while requester 0 waits on its read.
        set_req(0, 1'b0, 1'b1, '0, '0, 12'h020);
        nval = 0;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            if (|seen_val) nval++;
            if (c == 1) en = 1'b0;
            if (c == 5) en = 1'b1;
            if (c >= 2 && c <= 5) chk("stall_quiet", seen_val, 4'b0000);
            if (c == 7) begin
                chk("stall_valid", seen_val, 4'b0001);
                chk("stall_rdata", bus.read_data, 16'hBEEF);
            end
        end
        chk("stall_once", nval, 1);

        // Async reset in the middle of requester 1's write.
        set_req(0, 1'b1, 1'b0, 12'h040, 16'h7777, '0);
        set_req(1, 1'b1, 1'b0, 12'h030, 16'h5555, '0);
        step(1);
        chk("rw_we", bus.mem_write_enable, 1'b1);
        chk("rw_addr", bus.mem_write_addr, 12'h030);
        #1 rst = 1'b1;
        #1;
        chk("rw_we_drop", bus.mem_write_enable, 1'b0);
        chk("rw_busy_drop", bus.busy, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        chk("rw_mem_kept", mem[12'h030], 16'h0AAA);
        chk("rw_gid_rst", bus.grant_id, 0);
        ord.delete();
        for (int c = 1; c <= 8; c++) begin
            step(1);
            if (c == 1) begin
                chk("rw_regrant", bus.grant_id, 0);
                chk("rw_regrant_wa", bus.mem_write_addr, 12'h040);
            end
            if (|seen_ack) ord.push_back(oh2i(seen_ack));
        end
        chk("rw_count", ord.size(), 2);
        if (ord.size() == 2) begin
            chk("rw_first", ord[0], 0);
            chk("rw_second", ord[1], 1);
        end
        chk("rw_mem_new", mem[12'h030], 16'h5555);

        // Late request from 3 during 0's tenure; 0's re-request waits behind 3.
        set_req(0, 1'b1, 1'b0, 12'h050, 16'h0111, '0);
        ord.delete(); ocyc.delete();
        for (int c = 1; c <= 12; c++) begin
            step(1);
            if (|seen_ack) begin
                ord.push_back(oh2i(seen_ack));
                ocyc.push_back(c);
            end
            if (c == 1) set_req(3, 1'b1, 1'b0, 12'h053, 16'h0333, '0);
            if (c == 2) set_req(0, 1'b1, 1'b0, 12'h050, 16'h0222, '0);
        end
        chk("late_count", ord.size(), 3);
        if (ord.size() == 3) begin
            chk("late_a", ord[0], 0);
            chk("late_b", ord[1], 3);
            chk("late_c", ord[2], 0);
            chk("late_b_cyc", ocyc[1], 5);
        end
        chk("late_mem", mem[12'h050], 16'h0222);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
